// File: rtl/ansi_term_writer.sv
// Terminal byte-stream interpreter: printable chars, CR/LF/BS and a CSI subset
// (SGR colour, cursor position, erase) turned into character-RAM write cycles.
module ansi_term_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [12:0] o_address,
  output logic [7:0]  o_data,
  output logic        o_we,
  output logic [2:0]  o_fg,
  output logic [4:0]  o_cur_row,
  output logic [6:0]  o_cur_col
);

  localparam logic [6:0] LastCol  = 7'(COLS - 1);
  localparam logic [4:0] LastRow  = 5'(ROWS - 1);
  localparam logic [7:0] ColsByte = 8'(COLS);
  localparam logic [7:0] RowsByte = 8'(ROWS);

  typedef enum logic [1:0] {IDLE, ESC, CSI, CLEAR} state_t;

  state_t      state_q, state_d;
  logic [4:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  clrRow_q, clrRow_d;
  logic [6:0]  clrCol_q, clrCol_d;
  logic [4:0]  clrLastRow_q, clrLastRow_d;
  logic [2:0]  fg_q, fg_d;
  logic [7:0]  p0_q, p0_d;
  logic [7:0]  p1_q, p1_d;
  logic        sel_q, sel_d;
  logic        p1Seen_q, p1Seen_d;
  logic        we_q, we_d;
  logic [12:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        ready_q, ready_d;

  logic        accept;
  logic        isPrint;
  logic        isDigit;
  logic [4:0]  nextRow;

  assign accept  = i_valid && ready_q;
  assign isPrint = (i_data >= 8'h20) && (i_data <= 8'h7E);
  assign isDigit = (i_data >= 8'h30) && (i_data <= 8'h39);
  // No scrolling: the row after the last one is row 0 again.
  assign nextRow = (row_q == LastRow) ? 5'd0 : row_q + 5'd1;

  function automatic logic [7:0] accumDigit(input logic [7:0] p, input logic [7:0] ch);
    logic [11:0] t;
    t = ({4'd0, p} * 12'd10) + {4'd0, ch - 8'h30};
    return (t > 12'd255) ? 8'hFF : t[7:0];
  endfunction

  function automatic logic [2:0] sgrColour(input logic [2:0] cur, input logic [7:0] p);
    if (p == 8'd0) return 3'b111;
    else if ((p >= 8'd30) && (p <= 8'd37)) return 3'(p - 8'd30);
    else return cur;
  endfunction

  function automatic logic [4:0] clampRow(input logic [7:0] p);
    if (p == 8'd0) return 5'd0;
    else if (p >= RowsByte) return LastRow;
    else return 5'(p - 8'd1);
  endfunction

  function automatic logic [6:0] clampCol(input logic [7:0] p);
    if (p == 8'd0) return 7'd0;
    else if (p >= ColsByte) return LastCol;
    else return 7'(p - 8'd1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      clrRow_q     <= '0;
      clrCol_q     <= '0;
      clrLastRow_q <= '0;
      fg_q         <= 3'b111;
      p0_q         <= '0;
      p1_q         <= '0;
      sel_q        <= 1'b0;
      p1Seen_q     <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      clrRow_q     <= clrRow_d;
      clrCol_q     <= clrCol_d;
      clrLastRow_q <= clrLastRow_d;
      fg_q         <= fg_d;
      p0_q         <= p0_d;
      p1_q         <= p1_d;
      sel_q        <= sel_d;
      p1Seen_q     <= p1Seen_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      ready_q      <= ready_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    clrRow_d     = clrRow_q;
    clrCol_d     = clrCol_q;
    clrLastRow_d = clrLastRow_q;
    fg_d         = fg_q;
    p0_d         = p0_q;
    p1_d         = p1_q;
    sel_d        = sel_q;
    p1Seen_d     = p1Seen_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (isPrint) begin
            we_d   = 1'b1;
            addr_d = {1'b0, row_q, col_q};
            data_d = i_data;
            if (col_q == LastCol) begin
              col_d        = 7'd0;
              row_d        = nextRow;
              clrRow_d     = nextRow;
              clrCol_d     = 7'd0;
              clrLastRow_d = nextRow;
              state_d      = CLEAR;
            end else begin
              col_d = col_q + 7'd1;
            end
          end else if (i_data == 8'h0D) begin
            col_d = 7'd0;
          end else if (i_data == 8'h0A) begin
            row_d        = nextRow;
            clrRow_d     = nextRow;
            clrCol_d     = 7'd0;
            clrLastRow_d = nextRow;
            state_d      = CLEAR;
          end else if (i_data == 8'h08) begin
            if (col_q != 7'd0) col_d = col_q - 7'd1;
          end else if (i_data == 8'h1B) begin
            state_d = ESC;
          end
        end
      end

      ESC: begin
        if (accept) begin
          if (i_data == 8'h5B) begin
            state_d  = CSI;
            p0_d     = '0;
            p1_d     = '0;
            sel_d    = 1'b0;
            p1Seen_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      CSI: begin
        if (accept) begin
          if (isDigit) begin
            if (sel_q) begin
              p1_d     = accumDigit(p1_q, i_data);
              p1Seen_d = 1'b1;
            end else begin
              p0_d = accumDigit(p0_q, i_data);
            end
          end else if (i_data == 8'h3B) begin
            sel_d = 1'b1;
          end else if (i_data == 8'h1B) begin
            state_d = ESC;
          end else if ((i_data >= 8'h40) && (i_data <= 8'h7E)) begin
            state_d = IDLE;
            // p0 always counts (absent reads as 0); p1 only if digits were given.
            case (i_data)
              8'h6D: begin
                fg_d = sgrColour(fg_q, p0_q);
                if (p1Seen_q) fg_d = sgrColour(fg_d, p1_q);
              end
              8'h48: begin
                row_d = clampRow(p0_q);
                col_d = clampCol(p1_q);
              end
              8'h4A: begin
                if (p0_q == 8'd2) begin
                  clrRow_d     = 5'd0;
                  clrCol_d     = 7'd0;
                  clrLastRow_d = LastRow;
                  state_d      = CLEAR;
                end
              end
              8'h4B: begin
                clrRow_d     = row_q;
                clrCol_d     = col_q;
                clrLastRow_d = row_q;
                state_d      = CLEAR;
              end
              default: ;
            endcase
          end else begin
            state_d = IDLE;
          end
        end
      end

      CLEAR: begin
        we_d   = 1'b1;
        addr_d = {1'b0, clrRow_q, clrCol_q};
        data_d = 8'h20;
        if (clrCol_q == LastCol) begin
          clrCol_d = 7'd0;
          if (clrRow_q == clrLastRow_q) state_d = IDLE;
          else clrRow_d = clrRow_q + 5'd1;
        end else begin
          clrCol_d = clrCol_q + 7'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    ready_d = (state_d != CLEAR);
  end

  assign o_ready   = ready_q;
  assign o_address = addr_q;
  assign o_data    = data_q;
  assign o_we      = we_q;
  assign o_fg      = fg_q;
  assign o_cur_row = row_q;
  assign o_cur_col = col_q;

endmodule

// File: tb/tb_ansi_term_writer.sv
// Directed bench for ansi_term_writer: byte sequences in, VRAM write stream,
// cursor, colour and ready handshake compared against hand-computed values.
module tb_ansi_term_writer;

  logic        clk;
  logic        rst;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        o_ready;
  logic [12:0] o_address;
  logic [7:0]  o_data;
  logic        o_we;
  logic [2:0]  o_fg;
  logic [4:0]  o_cur_row;
  logic [6:0]  o_cur_col;

  int checks   = 0;
  int failures = 0;

  logic [12:0] wAddr[$];
  logic [7:0]  wData[$];
  int          readyLow = 0;

  ansi_term_writer dut (
    .clk       (clk),
    .rst       (rst),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_address (o_address),
    .o_data    (o_data),
    .o_we      (o_we),
    .o_fg      (o_fg),
    .o_cur_row (o_cur_row),
    .o_cur_col (o_cur_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every write and every not-ready cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_we) begin
        wAddr.push_back(o_address);
        wData.push_back(o_data);
      end
      if (!o_ready) readyLow++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    i_data  = b;
    i_valid = 1'b1;
    while (!o_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) checkOutput("ready_timeout", 32'(o_ready), 32'd1);
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  task automatic sendStr(input string s);
    for (int i = 0; i < s.len(); i++) applyStimulus(8'(s[i]));
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge clk);
    while (!o_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) checkOutput("idle_timeout", 32'(o_ready), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [12:0] cellAddr(input int r, input int c);
    return 13'((r << 7) | c);
  endfunction

  initial begin
    int base;
    int lowBase;
    int bad;

    rst     = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("rst_we", 32'(o_we), 32'd0);
    checkOutput("rst_ready", 32'(o_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_addr", 32'(o_address), 32'd0);
    checkOutput("rst_data", 32'(o_data), 32'd0);
    checkOutput("rst_fg", 32'(o_fg), 32'd7);
    checkOutput("rst_cursor", {o_cur_row, o_cur_col}, 32'd0);

    // "Hi" at the origin
    base = wAddr.size(); lowBase = readyLow;
    sendStr("Hi");
    waitIdle();
    checkOutput("hi_count", wAddr.size() - base, 32'd2);
    checkOutput("hi_w0", {wAddr[base], wData[base]}, {13'h0000, 8'h48});
    checkOutput("hi_w1", {wAddr[base+1], wData[base+1]}, {13'h0001, 8'h69});
    checkOutput("hi_cursor", {o_cur_row, o_cur_col}, {5'd0, 7'd2});
    checkOutput("hi_readylow", readyLow - lowBase, 32'd0);

    // Clamp/saturate: ESC[999;200H lands on the last cell
    sendStr("\033[999;200H");
    waitIdle();
    checkOutput("h_sat_cursor", {o_cur_row, o_cur_col}, {5'd29, 7'd79});

    // Printable at col 79 wraps and clears the next row
    sendStr("\033[1;999H");
    waitIdle();
    checkOutput("h_col79", {o_cur_row, o_cur_col}, {5'd0, 7'd79});
    base = wAddr.size(); lowBase = readyLow;
    applyStimulus(8'h41);
    @(negedge clk);
    checkOutput("wrap_ready_low", 32'(o_ready), 32'd0);
    waitIdle();
    checkOutput("wrap_count", wAddr.size() - base, 32'd81);
    checkOutput("wrap_char", {wAddr[base], wData[base]}, {13'h004F, 8'h41});
    bad = 0;
    for (int c = 0; c < 80; c++)
      if (wAddr[base+1+c] !== cellAddr(1, c) || wData[base+1+c] !== 8'h20) bad++;
    checkOutput("wrap_clear_cells", bad, 32'd0);
    checkOutput("wrap_readylow", readyLow - lowBase, 32'd80);
    checkOutput("wrap_cursor", {o_cur_row, o_cur_col}, {5'd1, 7'd0});

    // SGR colour
    base = wAddr.size();
    sendStr("\033[31m");
    waitIdle();
    checkOutput("sgr31", 32'(o_fg), 32'd1);
    sendStr("\033[0m");
    waitIdle();
    checkOutput("sgr0", 32'(o_fg), 32'd7);
    sendStr("\033[0;34m");
    waitIdle();
    checkOutput("sgr0_34", 32'(o_fg), 32'd4);
    sendStr("\033[40m");
    waitIdle();
    checkOutput("sgr40_ignored", 32'(o_fg), 32'd4);
    sendStr("\033[m");
    waitIdle();
    checkOutput("sgr_empty", 32'(o_fg), 32'd7);
    checkOutput("sgr_no_writes", wAddr.size() - base, 32'd0);

    // Cursor positioning then a character
    sendStr("\033[5;10Hx");
    waitIdle();
    checkOutput("pos_write", {wAddr[wAddr.size()-1], wData[wData.size()-1]}, {13'h0209, 8'h78});
    checkOutput("pos_cursor", {o_cur_row, o_cur_col}, {5'd4, 7'd10});

    // Full-screen clear with the next byte held waiting
    base = wAddr.size(); lowBase = readyLow;
    sendStr("\033[2J");
    applyStimulus(8'h5A);
    waitIdle();
    checkOutput("j_count", wAddr.size() - base, 32'd2401);
    bad = 0;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++)
        if (wAddr[base + r*80 + c] !== cellAddr(r, c) || wData[base + r*80 + c] !== 8'h20) bad++;
    checkOutput("j_cells", bad, 32'd0);
    checkOutput("j_held_byte", {wAddr[base+2400], wData[base+2400]}, {13'h020A, 8'h5A});
    checkOutput("j_readylow", readyLow - lowBase, 32'd2400);
    checkOutput("j_cursor", {o_cur_row, o_cur_col}, {5'd4, 7'd11});

    // Erase to end of line from col 11
    base = wAddr.size();
    sendStr("\033[K");
    waitIdle();
    checkOutput("k_count", wAddr.size() - base, 32'd69);
    checkOutput("k_first", 32'(wAddr[base]), 32'h020B);
    checkOutput("k_last", 32'(wAddr[base+68]), 32'h024F);
    checkOutput("k_cursor", {o_cur_row, o_cur_col}, {5'd4, 7'd11});

    // LF on the last row wraps to row 0 and clears it
    sendStr("\033[30;1H");
    waitIdle();
    base = wAddr.size();
    applyStimulus(8'h0A);
    waitIdle();
    checkOutput("lf_count", wAddr.size() - base, 32'd80);
    checkOutput("lf_first", 32'(wAddr[base]), 32'h0000);
    checkOutput("lf_last", 32'(wAddr[base+79]), 32'h004F);
    checkOutput("lf_cursor", {o_cur_row, o_cur_col}, {5'd0, 7'd0});
    base = wAddr.size();
    sendStr("\033QB");
    waitIdle();
    checkOutput("esc_abort_count", wAddr.size() - base, 32'd1);
    checkOutput("esc_abort_write", {wAddr[base], wData[base]}, {13'h0000, 8'h42});

    // BS, CR, DEL and a CSI aborted by ':'
    base = wAddr.size();
    sendStr("ab\010");
    applyStimulus(8'h7F);
    waitIdle();
    checkOutput("bs_col", 32'(o_cur_col), 32'd2);
    sendStr("\r\010");
    waitIdle();
    checkOutput("cr_bs_col", 32'(o_cur_col), 32'd0);
    sendStr("\033[:c");
    waitIdle();
    checkOutput("misc_count", wAddr.size() - base, 32'd3);
    checkOutput("csi_abort_write", {wAddr[base+2], wData[base+2]}, {13'h0000, 8'h63});

    // Reset in the middle of a full clear
    sendStr("\033[32m\033[2J");
    repeat (10) @(negedge clk);
    checkOutput("midclr_busy", 32'(o_ready), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("midclr_rst_ready", 32'(o_ready), 32'd1);
    checkOutput("midclr_rst_we", 32'(o_we), 32'd0);
    checkOutput("midclr_rst_fg", 32'(o_fg), 32'd7);
    checkOutput("midclr_rst_addr", 32'(o_address), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = wAddr.size();
    applyStimulus(8'h51);
    waitIdle();
    checkOutput("post_rst_count", wAddr.size() - base, 32'd1);
    checkOutput("post_rst_write", {wAddr[base], wData[base]}, {13'h0000, 8'h51});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ansi_term_writer.md
# ansi_term_writer

Terminal-side consumer of the UART byte stream: takes received bytes, interprets printable characters, CR/LF/BS and a subset of ANSI CSI escape sequences, and issues write cycles into the text character buffer (80×30 cells, 8-bit char codes). It sits between the UART receiver and port A of the dual-port character RAM. It is the decoding end of the ESC[…m colour sequences the terminal prompt emits.

## Interface
- COLS, 80, visible columns per row
- ROWS, 30, visible rows

- clk  in  1  system/pixel clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- i_data  in  8  received byte
- i_valid  in  1  byte present; accepted when i_valid && o_ready
- o_ready  out  1  block can accept a byte
- o_address  out  13  VRAM write address = {1'b0, row[4:0], col[6:0]}
- o_data  out  8  character code to write
- o_we  out  1  write strobe, one cell per cycle
- o_fg  out  3  current SGR foreground colour (RGB bits)
- o_cur_row  out  5  cursor row, 0..ROWS-1
- o_cur_col  out  7  cursor column, 0..COLS-1

## Operation
- States: IDLE, ESC, CSI, CLEAR.
- IDLE, accepted byte:
  - 0x20..0x7E: write byte at cursor; col+1. If col reaches COLS: col=0, advance row (see below).
  - 0x0D CR: col=0. 0x0A LF: advance row. 0x08 BS: col-1 if col>0, else unchanged. 0x1B: go ESC. All other bytes (incl. 0x7F): dropped.
- Advance row: row+1, wrapping ROWS-1 → 0 (no scroll); then enter CLEAR for the new row, cols 0..COLS-1 filled with 0x20.
- ESC: '[' → CSI, clear params; any other byte → IDLE, byte dropped.
- CSI: up to two decimal params p0,p1 (8 bit, saturate at 255, absent = 0). Digits accumulate (p*10+d) into current param; ';' selects p1 (further ';' ignored). 0x1B restarts in ESC. Final bytes:
  - 'm': per param present (p0, then p1): 0 → o_fg=3'b111; 30..37 → o_fg=value-30; others ignored. Empty ESC[m = reset.
  - 'H': row=clamp(p0,1,ROWS)-1, col=clamp(p1,1,COLS)-1.
  - 'J' with p0==2: CLEAR whole screen (ROWS×COLS cells from 0,0); cursor unchanged. Other p0 ignored.
  - 'K': CLEAR from cursor col to COLS-1 in cursor row; cursor unchanged.
  - Any other byte 0x40..0x7E: ignored. Then → IDLE.
  - Bytes outside '0'-'9', ';', 0x40..0x7E, ESC: abort to IDLE.
- CLEAR: internal row/col counter writes 0x20 one cell per cycle, o_we high each cycle; returns to IDLE after last cell.

## Timing
- Reset: o_we=0, o_address=0, o_data=0, o_ready=1, o_fg=3'b111, cursor (0,0), state IDLE.
- All outputs registered. Write for an accepted printable byte appears on o_we/o_address/o_data the cycle after acceptance, one-cycle pulse; cursor updates same edge.
- o_ready=1 in IDLE/ESC/CSI; 0 from the edge entering CLEAR until the edge after the last clear write. Clear durations: row 80 cycles, 'K' COLS-col cycles, 'J' 2400 cycles. Back-to-back bytes accepted every cycle otherwise.
- Printable at col 79: char written at col 79, then row clear of next row starts next cycle (o_ready low one cycle after acceptance).
- Bytes with i_valid high and o_ready low are not consumed; source holds them.
- rst mid-CLEAR or mid-sequence: immediate return to reset values; partial clear not resumed.
- Address arithmetic: col 7 bits, row 5 bits; no address ever exceeds row 29/col 79.

## Test plan
- Reset, send "Hi" → writes 0x48 @ addr 0x0000, 0x69 @ 0x0001; cursor (0,2); o_ready stays 1.
- Cursor at (0,79), send 'A' → write 0x41 @ 0x004F, then 80 writes of 0x20 at 0x0080..0x00CF, o_ready low 80 cycles; cursor (1,0).
- Send ESC[31m, then ESC[0m → o_fg=3'b001, then 3'b111; no o_we pulses.
- Send ESC[5;10H then 'x' → write 0x78 @ {row 4, col 9} = 0x0209; cursor (4,10).
- Send ESC[2J with i_valid held high on next byte → 2400 writes of 0x20 covering all cells, next byte accepted only after last write.
- Cursor row 29, send LF → row wraps to 0, row 0 cleared; send ESC 'Q' 'B' → ESC aborted, 'B' written at (0,0).
